seg7_bcd_scan: RTL and testbench
================================

SEG7_BCD_SCAN -- requirements
Module: seg7_bcd_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter UPDATE_DIV, default 10000000, clock cycles between value samples (10 Hz).
REQ-003 SHALL have port clk_100MHz_i  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port val_1_i  input  16  unsigned value for the right group (digits 3..0).
REQ-006 SHALL have port val_2_i  input  16  unsigned value for the left group (digits 7..4).
REQ-007 SHALL have port seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp_o  output  1  decimal point, active-low.
REQ-009 SHALL have port an_o  output  8  anodes, active-low one-hot; an_o[0] is the rightmost digit.
REQ-010 SHALL have port busy_o  output  1  high while conversion runs.

Function
REQ-011 Update prescaler SHALL count 0..UPDATE_DIV-1 and assert a one-cycle update tick at terminal count, then wrap to 0.
REQ-012 On tick in IDLE, both inputs SHALL be captured in the same cycle; values >9999 SHALL be saturated to 9999 and the group's overflow flag set, otherwise cleared.
REQ-013 FSM states: IDLE, CONV1, CONV2, LATCH; IDLE->CONV1 on tick; CONV1->CONV2 after 16 cycles; CONV2->LATCH after 16 cycles; LATCH->IDLE after 1 cycle.
REQ-014 Each CONV iteration SHALL, in one cycle, add 3 to every BCD nibble >=5, then shift the binary MSB into the BCD register (double-dabble).
REQ-015 In LATCH, both 4-digit BCD results and both overflow flags SHALL be transferred atomically to the display register; tick-to-display latency is 34 cycles.
REQ-016 busy_o SHALL be high in CONV1, CONV2 and LATCH, low in IDLE.
REQ-017 A tick arriving while not in IDLE SHALL be ignored (no queueing); the display keeps its previous contents.
REQ-018 Scan prescaler SHALL count 0..REFRESH_DIV-1; at terminal count the digit index SHALL advance 0..7 and wrap 7->0.
REQ-019 an_o SHALL drive low only the bit equal to the digit index; digits 3..0 show val_1 thousands..ones, digits 7..4 show val_2 thousands..ones.
REQ-020 Leading zeros SHALL be blanked (seg_o = 7'h7F) per group; each group's ones digit SHALL always be displayed, including 0.
REQ-021 dp_o SHALL be low only on digit 3 when val_1 overflowed and on digit 7 when val_2 overflowed; high otherwise.
REQ-022 Segment patterns SHALL be standard 0-9 active-low (e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00).
REQ-023 Outputs SHALL be registered; an_o, seg_o and dp_o SHALL change in the same cycle.

Reset
REQ-024 While rst is high: an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1, busy_o = 0, FSM = IDLE, prescalers = 0, digit index = 0, display register = 0 with flags cleared.
REQ-025 Reset asserted mid-conversion SHALL abort it; the display register SHALL NOT be updated with partial results.
REQ-026 After release, the first tick SHALL occur UPDATE_DIV cycles later; before it, digits 0 and 4 show "0".

Structure
REQ-027 Package seg7_pkg SHALL hold the FSM state enum typedef, the 10-entry segment lookup constant, the blank pattern and BCD_MAX = 9999.
REQ-028 Double-dabble engine SHALL be a sub-module bin2bcd_seq (start, 16-bit in, 16-bit BCD out, done), instantiated once and reused for both values.
REQ-029 Scan counter, mux and segment lookup SHALL stay in seg7_bcd_scan.

Verification (REFRESH_DIV=4, UPDATE_DIV=64)
REQ-030 val_1=1234, val_2=56, tick -> after 34 cycles, over one 32-cycle scan: digits 3..0 = 1,2,3,4; digits 7..4 = blank,blank,5,6; dp_o high throughout.
REQ-031 val_1=0, val_2=65535 -> digit 0 = "0" (7'h40), digits 3..1 blank; digits 7..4 = 9,9,9,9; dp_o low only while an_o=8'h7F.
REQ-032 Change inputs during CONV1 -> displayed values are those captured at the tick; busy_o high exactly 33 cycles.
REQ-033 Assert rst at cycle 10 of CONV2 -> outputs at reset values; after release, previous display never reappears; first display update comes from the next tick.
REQ-034 Free-run 3 scans -> an_o sequence FE,FD,FB,F7,EF,DF,BF,7F repeating, each held 4 cycles, exactly one bit low at all times outside reset.
REQ-035 Random sweep of 200 value pairs -> every displayed digit matches a decimal model of min(val,9999) with correct blanking and dp.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit BCD scanning display:
// FSM state encoding, segment lookup, blank pattern and saturation helper.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV1,
        ST_CONV2,
        ST_LATCH
    } state_t;

    localparam logic [15:0] BCD_MAX     = 16'd9999;
    localparam int          CONV_CYCLES = 16;
    localparam logic [6:0]  SEG_BLANK   = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the pattern for digit 0.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic        ovf;
        logic [15:0] val;
    } sat_t;

    function automatic sat_t saturate(input logic [15:0] v);
        sat_t s;
        s.ovf = (v > BCD_MAX);
        s.val = s.ovf ? BCD_MAX : v;
        return s;
    endfunction

endpackage

// File: rtl/seg7_bcd_scan_bin2bcd.sv
// Sequential double-dabble converter: 16 iterations, the first one performed
// on the start edge itself so a full conversion spans exactly 16 clocks.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic [15:0] bcd_out,
    output logic        done
);

    logic [15:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [4:0]  cnt_reg;

    logic [15:0] src_bcd;
    logic [15:0] src_bin;
    logic [15:0] adj_bcd;
    logic        running;

    // A start restarts from an empty BCD register regardless of prior state.
    assign src_bcd = start ? 16'd0 : bcd_reg;
    assign src_bin = start ? bin_in : bin_reg;
    assign running = (cnt_reg != 5'd0) && (cnt_reg != 5'(CONV_CYCLES));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign adj_bcd[gi*4 +: 4] = (src_bcd[gi*4 +: 4] >= 4'd5)
                                        ? src_bcd[gi*4 +: 4] + 4'd3
                                        : src_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            cnt_reg <= '0;
        end else if (start || running) begin
            bcd_reg <= (adj_bcd << 1) | 16'(src_bin[15]);
            bin_reg <= src_bin << 1;
            cnt_reg <= start ? 5'd1 : cnt_reg + 5'd1;
        end
    end

    assign bcd_out = bcd_reg;
    assign done    = (cnt_reg == 5'(CONV_CYCLES));

endmodule

// File: rtl/seg7_bcd_scan.sv
// Two 4-digit decimal groups on an 8-digit multiplexed display. Values are
// sampled periodically, converted with one shared BCD engine, then scanned out.
module seg7_bcd_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int UPDATE_DIV  = 10000000
) (
    input  logic        clk_100MHz_i,
    input  logic        rst,
    input  logic [15:0] val_1_i,
    input  logic [15:0] val_2_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        busy_o
);

    localparam int UPD_W  = $clog2(UPDATE_DIV + 1);
    localparam int SCAN_W = $clog2(REFRESH_DIV + 1);

    logic [UPD_W-1:0]  upd_cnt_reg;
    logic              upd_tick;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [2:0]        digit_idx_reg;

    state_t      state_reg, state_next;
    logic [3:0]  phase_reg, phase_next;

    logic [15:0] cap1_reg, cap2_reg;
    logic        ovf1_reg, ovf2_reg;
    logic [15:0] res1_reg;
    logic [15:0] disp_bcd1_reg, disp_bcd2_reg;
    logic        disp_ovf1_reg, disp_ovf2_reg;

    logic        eng_start;
    logic [15:0] eng_in;
    logic [15:0] eng_bcd;
    logic        eng_done;
    logic        res1_save;
    logic        disp_load;

    sat_t        sat1, sat2;

    logic [6:0]  seg_reg, seg_next;
    logic        dp_reg, dp_next;
    logic [7:0]  an_reg, an_next;

    // ---------------- update prescaler ----------------
    assign upd_tick = (upd_cnt_reg == UPD_W'(UPDATE_DIV - 1));

    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst)
            upd_cnt_reg <= '0;
        else if (upd_tick)
            upd_cnt_reg <= '0;
        else
            upd_cnt_reg <= upd_cnt_reg + 1'b1;
    end

    // ---------------- capture / conversion FSM ----------------
    assign sat1 = saturate(val_1_i);
    assign sat2 = saturate(val_2_i);

    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        eng_start  = 1'b0;
        eng_in     = cap1_reg;
        res1_save  = 1'b0;
        disp_load  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (upd_tick) begin
                    state_next = ST_CONV1;
                    phase_next = '0;
                end
            end
            ST_CONV1: begin
                eng_start  = (phase_reg == 4'd0);
                phase_next = phase_reg + 4'd1;
                if (phase_reg == 4'd15)
                    state_next = ST_CONV2;
            end
            ST_CONV2: begin
                // The engine still holds the first result on this group's
                // opening cycle; grab it in the same edge that restarts it.
                eng_start  = (phase_reg == 4'd0);
                eng_in     = cap2_reg;
                res1_save  = (phase_reg == 4'd0) && eng_done;
                phase_next = phase_reg + 4'd1;
                if (phase_reg == 4'd15)
                    state_next = ST_LATCH;
            end
            ST_LATCH: begin
                disp_load  = eng_done;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst) begin
            cap1_reg <= '0;
            cap2_reg <= '0;
            ovf1_reg <= 1'b0;
            ovf2_reg <= 1'b0;
            res1_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && upd_tick) begin
                cap1_reg <= sat1.val;
                ovf1_reg <= sat1.ovf;
                cap2_reg <= sat2.val;
                ovf2_reg <= sat2.ovf;
            end
            if (res1_save)
                res1_reg <= eng_bcd;
        end
    end

    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst) begin
            disp_bcd1_reg <= '0;
            disp_bcd2_reg <= '0;
            disp_ovf1_reg <= 1'b0;
            disp_ovf2_reg <= 1'b0;
        end else if (disp_load) begin
            disp_bcd1_reg <= res1_reg;
            disp_bcd2_reg <= eng_bcd;
            disp_ovf1_reg <= ovf1_reg;
            disp_ovf2_reg <= ovf2_reg;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk_100MHz_i),
        .rst     (rst),
        .start   (eng_start),
        .bin_in  (eng_in),
        .bcd_out (eng_bcd),
        .done    (eng_done)
    );

    assign busy_o = (state_reg != ST_IDLE);

    // ---------------- digit scan ----------------
    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
        end else if (scan_cnt_reg == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= digit_idx_reg + 3'd1;
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + 1'b1;
        end
    end

    logic        grp_sel;
    logic [1:0]  pos_sel;
    logic [15:0] sel_bcd;
    logic        sel_ovf;
    logic [3:0]  sel_nib;
    logic [3:0]  lead_zero;

    assign grp_sel = digit_idx_reg[2];
    assign pos_sel = digit_idx_reg[1:0];
    assign sel_bcd = grp_sel ? disp_bcd2_reg : disp_bcd1_reg;
    assign sel_ovf = grp_sel ? disp_ovf2_reg : disp_ovf1_reg;
    assign sel_nib = sel_bcd[{pos_sel, 2'b00} +: 4];

    // A position is a leading zero when it and every higher digit are zero;
    // the ones position is never blanked.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_ones
                assign lead_zero[gi] = 1'b0;
            end else begin : g_upper
                assign lead_zero[gi] = (sel_bcd[15:gi*4] == '0);
            end
        end
    endgenerate

    always_comb begin
        seg_next = SEG_BLANK;
        if (!lead_zero[pos_sel] && sel_nib <= 4'd9)
            seg_next = SEG_LUT[sel_nib];
        dp_next = ~((pos_sel == 2'd3) && sel_ovf);
        an_next = ~(8'd1 << digit_idx_reg);
    end

    always_ff @(posedge clk_100MHz_i or posedge rst) begin
        if (rst) begin
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
            an_reg  <= 8'hFF;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg_o = seg_reg;
    assign dp_o  = dp_reg;
    assign an_o  = an_reg;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed and swept checks of the BCD scanning display with short dividers
// (REFRESH_DIV=4, UPDATE_DIV=64); expected digits come from a decimal model.
module tb_seg7_bcd_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val_1 = '0;
    logic [15:0] val_2 = '0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        busy_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] dir1 [4] = '{16'd9999, 16'd10000, 16'd10,  16'd1000};
    logic [15:0] dir2 [4] = '{16'd10000, 16'd9999, 16'd100, 16'd7};

    always #5 clk = ~clk;

    seg7_bcd_scan #(.REFRESH_DIV(4), .UPDATE_DIV(64)) dut (
        .clk_100MHz_i (clk),
        .rst          (rst),
        .val_1_i      (val_1),
        .val_2_i      (val_2),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .an_o         (an_o),
        .busy_o       (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int pow10(input int p);
        case (p)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] raw, input int pos);
        int v;
        v = (raw > 16'd9999) ? 9999 : int'(raw);
        if (pos > 0 && v < pow10(pos))
            return 7'h7F;
        return seg_of((v / pow10(pos)) % 10);
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 9));
            1: return 16'($urandom_range(0, 999));
            2: return 16'($urandom_range(0, 9999));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " an"},   32'(an_o),   32'hFF);
        check_eq({tag, " seg"},  32'(seg_o),  32'h7F);
        check_eq({tag, " dp"},   32'(dp_o),   32'h1);
        check_eq({tag, " busy"}, 32'(busy_o), 32'h0);
    endtask

    // Returns at the first sample where busy_o is seen newly high,
    // i.e. one half-cycle after the capture edge.
    task automatic wait_capture(input string tag);
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = busy_o;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (busy_o && !prev) begin
                found = 1'b1;
                break;
            end
            prev = busy_o;
        end
        check_eq({tag, " capture"}, 32'(found), 32'h1);
    endtask

    // Samples 32 consecutive cycles (one full scan) and checks every digit.
    task automatic scan_check(input logic [15:0] v1, input logic [15:0] v2, input string tag);
        int          bad0;
        int          zeros;
        int          idx;
        logic [7:0]  seen;
        logic [15:0] raw;
        bad0 = n_bad;
        seen = '0;
        for (int i = 0; i < 32; i++) begin
            zeros = 0;
            idx   = 0;
            for (int j = 0; j < 8; j++) begin
                if (!an_o[j]) begin
                    zeros++;
                    idx = j;
                end
            end
            check_eq({tag, " an_onehot"}, 32'(zeros), 32'd1);
            if (zeros == 1) begin
                seen[idx] = 1'b1;
                raw = (idx >= 4) ? v2 : v1;
                check_eq($sformatf("%s seg digit%0d", tag, idx), 32'(seg_o), 32'(exp_seg(raw, idx % 4)));
                check_eq($sformatf("%s dp digit%0d", tag, idx), 32'(dp_o),
                         32'((idx % 4 == 3 && raw > 16'd9999) ? 1'b0 : 1'b1));
            end
            @(negedge clk);
        end
        check_eq({tag, " all_digits"}, 32'(seen), 32'hFF);
        $display("%s val_1=%0d val_2=%0d errors=%0d", tag, v1, v2, n_bad - bad0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        int          k;
        int          run;
        bit          first_run;
        logic [7:0]  prev_an;

        // Reset state
        rst   = 1'b1;
        val_1 = 16'd1234;
        val_2 = 16'd56;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic conversion
        wait_capture("t1");
        repeat (34) @(negedge clk);
        scan_check(16'd1234, 16'd56, "t1");

        // Zero and saturated overflow
        val_1 = 16'd0;
        val_2 = 16'd65535;
        wait_capture("t2");
        repeat (34) @(negedge clk);
        scan_check(16'd0, 16'd65535, "t2");

        // Inputs change during conversion; busy duration
        val_1 = 16'd4321;
        val_2 = 16'd789;
        wait_capture("t3");
        val_1 = 16'd9;
        val_2 = 16'd1000;
        nb = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_o) nb++;
            else break;
        end
        check_eq("t3 busy_cycles", 32'(nb), 32'd33);
        @(negedge clk);
        scan_check(16'd4321, 16'd789, "t3");

        // Reset in the middle of the second conversion
        val_1 = 16'd7777;
        val_2 = 16'd8888;
        wait_capture("t4");
        repeat (26) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("t4 midreset");
        repeat (3) @(negedge clk);
        val_1 = 16'd5;
        val_2 = 16'd6;
        rst = 1'b0;
        @(negedge clk);
        scan_check(16'd0, 16'd0, "t4 cleared");
        k = 33;
        while (!busy_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4 first_tick", 32'(k), 32'd64);
        repeat (34) @(negedge clk);
        scan_check(16'd5, 16'd6, "t4 after");

        // Free-running anode sequence over three scans
        prev_an   = an_o;
        run       = 1;
        first_run = 1'b1;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            check_eq("t5 an_onehot", 32'($countones(~an_o)), 32'd1);
            if (an_o != prev_an) begin
                check_eq("t5 an_seq", 32'(an_o), 32'({prev_an[6:0], prev_an[7]}));
                if (!first_run)
                    check_eq("t5 an_hold", 32'(run), 32'd4);
                first_run = 1'b0;
                run       = 1;
                prev_an   = an_o;
            end else begin
                run++;
            end
        end
        $display("t5 anode scan errors=%0d", n_bad);

        // Boundary pairs, then random sweep
        for (int p = 0; p < 204; p++) begin
            if (p < 4) begin
                val_1 = dir1[p];
                val_2 = dir2[p];
            end else begin
                val_1 = rand_val();
                val_2 = rand_val();
            end
            wait_capture($sformatf("sweep%0d", p));
            repeat (34) @(negedge clk);
            scan_check(val_1, val_2, $sformatf("sweep%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
